// File: rtl/memq_target.sv
// memq_target: bus target with per-address write-version memory, fixed-latency read
// pipeline and a response FIFO that back-pressures the arbiter through ready.
module memq_target #(
   parameter int WIDTH     = 2,
   parameter int DWIDTH    = 4,
   parameter int LATENCY   = 2,
   parameter int RDEPTH    = 4,
   parameter int LOGRDEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              validin,
   input  logic              isread,
   input  logic [WIDTH-1:0]  addr,
   input  logic              src,
   output logic              ready,
   output logic              resp_valid,
   output logic              resp_src,
   output logic [WIDTH-1:0]  resp_addr,
   output logic [DWIDTH-1:0] resp_data,
   input  logic              resp_accept,
   output logic              overrun
);
   localparam int CW = LOGRDEPTH + 1;
   logic [DWIDTH-1:0]    mem_q [2**WIDTH];
   logic [LATENCY-1:0]   pv_q, ps_q;
   logic [WIDTH-1:0]     pa_q [LATENCY];
   logic [DWIDTH-1:0]    pd_q [LATENCY];
   logic [RDEPTH-1:0]    fs_q;
   logic [WIDTH-1:0]     fa_q [RDEPTH];
   logic [DWIDTH-1:0]    fd_q [RDEPTH];
   logic [LOGRDEPTH-1:0] wp_q, rp_q;
   logic [CW-1:0]        cnt_q, cnt_d, inf_q, inf_d;
   logic                 ovr_q, acc, rd, push, pop;
   // Reads in flight are reserved against FIFO space, so a push can never find it full.
   assign ready      = ({1'b0, cnt_q} + {1'b0, inf_q}) < (CW+1)'(RDEPTH);
   assign acc        = validin && ready;
   assign rd         = acc && isread;
   assign push       = pv_q[LATENCY-1];
   assign resp_valid = cnt_q != '0;
   assign pop        = resp_valid && resp_accept;
   assign resp_src   = resp_valid && fs_q[rp_q];
   assign resp_addr  = resp_valid ? fa_q[rp_q] : '0;
   assign resp_data  = resp_valid ? fd_q[rp_q] : '0;
   assign overrun    = ovr_q;
   always_comb begin
      cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
      inf_d = (rd && !push) ? inf_q + 1'b1 : (push && !rd) ? inf_q - 1'b1 : inf_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2**WIDTH; i++) mem_q[i] <= '0;
         pv_q  <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         inf_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         if (acc && !isread) mem_q[addr] <= mem_q[addr] + 1'b1;
         pv_q[0] <= rd;
         ps_q[0] <= src;
         pa_q[0] <= addr;
         pd_q[0] <= mem_q[addr];
         for (int i = 1; i < LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            ps_q[i] <= ps_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
         if (push) begin
            fs_q[wp_q] <= ps_q[LATENCY-1];
            fa_q[wp_q] <= pa_q[LATENCY-1];
            fd_q[wp_q] <= pd_q[LATENCY-1];
         end
         wp_q  <= push ? wp_q + 1'b1 : wp_q;
         rp_q  <= pop ? rp_q + 1'b1 : rp_q;
         cnt_q <= cnt_d;
         inf_q <= inf_d;
         ovr_q <= ovr_q || (validin && !ready);
      end
   end
endmodule

// File: tb/tb_memq_target.sv
// tb_memq_target: directed stimulus for memq_target with a scoreboard of expected
// read responses and a reference model of memory, occupancy and overrun.
module tb_memq_target;
   localparam int LAT = 2;
   localparam int RD  = 4;
   logic       clock = 1'b0, reset, validin, isread, src, resp_accept;
   logic [1:0] addr, resp_addr;
   logic [3:0] resp_data;
   logic       ready, resp_valid, resp_src, overrun;
   typedef struct {logic s; logic [1:0] a; logic [3:0] d; int at;} ent_t;
   ent_t       sb[$];
   logic [3:0] mm [4];
   logic       exp_ovr;
   int         cyc, pass_n, fail_n, tot_n;
   memq_target #(.WIDTH(2), .DWIDTH(4), .LATENCY(LAT), .RDEPTH(RD), .LOGRDEPTH(2)) dut (
      .clock(clock), .reset(reset), .validin(validin), .isread(isread), .addr(addr),
      .src(src), .ready(ready), .resp_valid(resp_valid), .resp_src(resp_src),
      .resp_addr(resp_addr), .resp_data(resp_data), .resp_accept(resp_accept),
      .overrun(overrun)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tot_n++;
      assert (obs === expv) pass_n++;
      else begin
         fail_n++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic drv(input logic v, input logic r, input logic [1:0] a, input logic s,
                      input logic ra);
      validin = v; isread = r; addr = a; src = s; resp_accept = ra;
   endtask
   // Checks pre-edge outputs against the model, advances the model and the DUT by one edge.
   task automatic tick();
      bit er, rv;
      er = sb.size() < RD;
      rv = sb.size() != 0 && cyc >= sb[0].at;
      chk("ready", 8'(ready), 8'(er));
      chk("resp_valid", 8'(resp_valid), 8'(rv));
      if (rv) begin
         chk("resp_src", 8'(resp_src), 8'(sb[0].s));
         chk("resp_addr", 8'(resp_addr), 8'(sb[0].a));
         chk("resp_data", 8'(resp_data), 8'(sb[0].d));
      end
      if (reset) begin
         sb.delete();
         foreach (mm[i]) mm[i] = '0;
         exp_ovr = 1'b0;
      end else begin
         if (validin && !er) exp_ovr = 1'b1;
         if (rv && resp_accept) sb.delete(0);
         if (validin && er && isread) sb.push_back('{src, addr, mm[addr], cyc + 1 + LAT});
         else if (validin && er) mm[addr] = mm[addr] + 4'd1;
      end
      @(posedge clock);
      #1;
      cyc++;
      chk("overrun", 8'(overrun), 8'(exp_ovr));
   endtask
   initial begin
      pass_n = 0; fail_n = 0; tot_n = 0; cyc = 0; exp_ovr = 1'b0;
      foreach (mm[i]) mm[i] = '0;
      reset = 1'b1;
      drv(0, 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_ready", 8'(ready), 8'd1);
      chk("rst_resp_valid", 8'(resp_valid), 8'd0);
      chk("rst_overrun", 8'(overrun), 8'd0);
      chk("rst_resp_data", 8'(resp_data), 8'd0);
      chk("rst_resp_addr", 8'(resp_addr), 8'd0);
      chk("rst_resp_src", 8'(resp_src), 8'd0);
      repeat (5) tick();
      drv(1, 1, 2, 0, 0); tick();
      drv(0, 0, 0, 0, 0); repeat (LAT) tick();
      chk("rd2_valid", 8'(resp_valid), 8'd1);
      chk("rd2_data", 8'(resp_data), 8'd0);
      chk("rd2_addr", 8'(resp_addr), 8'd2);
      drv(0, 0, 0, 0, 1); tick();
      repeat (3) begin drv(1, 0, 1, 0, 0); tick(); end
      drv(1, 1, 1, 1, 0); tick();
      drv(0, 0, 0, 0, 0); repeat (LAT) tick();
      chk("raw_data", 8'(resp_data), 8'd3);
      chk("raw_src", 8'(resp_src), 8'd1);
      chk("raw_addr", 8'(resp_addr), 8'd1);
      drv(0, 0, 0, 0, 1); tick();
      for (int i = 0; i < 4; i++) begin drv(1, 1, 2'(i), 1'(i), 0); tick(); end
      chk("bp_ready_low", 8'(ready), 8'd0);
      drv(1, 0, 0, 0, 0); tick();
      chk("bp_overrun", 8'(overrun), 8'd1);
      drv(0, 0, 0, 0, 0); repeat (2) tick();
      drv(0, 0, 0, 0, 1); tick();
      chk("bp_ready_back", 8'(ready), 8'd1);
      repeat (3) tick();
      drv(1, 1, 0, 0, 1); tick();
      drv(0, 0, 0, 0, 1); repeat (LAT) tick();
      chk("dropped_write", 8'(resp_data), 8'd0);
      tick();
      for (int i = 0; i < 12; i++) begin drv(1, 1, 2'(i), 1'(i), 1); tick(); end
      drv(0, 0, 0, 0, 1); repeat (3) tick();
      chk("stream_drained", 8'(resp_valid), 8'd0);
      repeat (17) begin drv(1, 0, 3, 0, 0); tick(); end
      drv(1, 1, 3, 0, 0); tick();
      drv(0, 0, 0, 0, 0); repeat (LAT) tick();
      chk("wrap_data", 8'(resp_data), 8'd1);
      drv(0, 0, 0, 0, 1); tick();
      for (int i = 0; i < 3; i++) begin drv(1, 1, 2'(i), 0, 0); tick(); end
      drv(0, 0, 0, 0, 0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_valid", 8'(resp_valid), 8'd0);
      chk("mid_rst_ready", 8'(ready), 8'd1);
      chk("mid_rst_overrun", 8'(overrun), 8'd0);
      repeat (4) tick();
      drv(1, 1, 1, 1, 0); tick();
      drv(0, 0, 0, 0, 0); repeat (LAT) tick();
      chk("post_rst_data", 8'(resp_data), 8'd0);
      drv(0, 0, 0, 0, 1); repeat (2) tick();
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule

// File: doc/memq_target.md
Name: memq_target

Overview:
- Downstream bus target for the two-queue read/write sampler (the arbitrated read/write request queues).
- Consumes the granted request stream (valid, is-read, address, source queue) and models a small memory whose entries are per-address write-version counters.
- Returns read responses after a fixed pipeline latency through a response FIFO.
- Drives a `ready` back-pressure signal that the arbiter ANDs into its bus grant.

Parameters:
- WIDTH, 2, address width; memory has 2^WIDTH entries.
- DWIDTH, 4, width of each version counter and of the response data.
- LATENCY, 2, read pipeline stages (legal range 1..4).
- RDEPTH, 4, response FIFO depth (power of two).
- LOGRDEPTH, 2, log2(RDEPTH).

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- validin, input, 1, request present this cycle.
- isread, input, 1, 1 = read, 0 = write.
- addr, input, WIDTH, request address.
- src, input, 1, originating queue index (0/1).
- ready, output, 1, target can accept a request this cycle.
- resp_valid, output, 1, FIFO head holds a read response.
- resp_src, output, 1, src of head response.
- resp_addr, output, WIDTH, address of head response.
- resp_data, output, DWIDTH, version value read.
- resp_accept, input, 1, consumer pops head when resp_valid.
- overrun, output, 1, sticky: validin seen while ready = 0.

Behaviour:
- Reset (synchronous, checked on posedge):
  - all memory entries 0; pipeline valid bits 0; FIFO pointers and count 0; inflight 0; overrun 0.
  - Outputs after reset: ready = 1, resp_valid = 0, overrun = 0, resp_* = 0.
  - Reset mid-operation discards in-flight and queued responses and wipes memory.
  - Reset has priority over every other event in the same cycle.
- Acceptance:
  - accept = validin && ready.
  - Requests with validin && !ready are dropped, with no state change except overrun set to 1. overrun clears only on reset.
- Write (accept && !isread):
  - mem[addr] <= mem[addr] + 1, modulo 2^DWIDTH (wraps from 2^DWIDTH-1 to 0).
  - No response is generated.
- Read (accept && isread):
  - Samples mem[addr] as registered before this edge.
  - Loads stage 0 of the pipeline with {1, src, addr, data}.
  - Stages shift every cycle unconditionally.
  - Stage LATENCY-1 is pushed into the FIFO at the next edge.
  - A read accepted at edge t is visible at resp_* (FIFO empty) right after edge t+LATENCY.
- Read after write:
  - A read accepted on the edge after a write to the same address returns the incremented value.
  - Only one request per cycle exists, so there is no same-edge read/write conflict.
- inflight:
  - Count of valid pipeline stages, width LOGRDEPTH+1.
  - +1 on read accept, -1 on FIFO push, unchanged if both occur.
- FIFO count:
  - Range 0..RDEPTH, width LOGRDEPTH+1.
  - Push and pop in the same cycle leaves count unchanged and both pointers advance.
  - Pointers wrap modulo RDEPTH.
  - Pop occurs only when resp_valid && resp_accept; resp_accept with an empty FIFO is ignored.
- ready:
  - Combinational from registers: ready = (count + inflight) < RDEPTH.
  - ready deasserts for writes too, even though writes need no FIFO slot.
  - This guarantees a FIFO push never hits a full FIFO.
- resp_valid = (count != 0). resp_src, resp_addr and resp_data come from the head entry, combinationally.
- Pipeline state: no FSM beyond the pipeline and FIFO. Per-stage state is {valid, src, addr, data}.

Test Plan:
- Reset, then idle 5 cycles -> ready = 1, resp_valid = 0, overrun = 0. Read addr 2 -> resp after 2 edges with resp_data = 0, resp_addr = 2.
- Write addr 1 three times, then read addr 1 on the next edge (src = 1) -> after LATENCY edges: resp_data = 3, resp_src = 1, resp_addr = 1.
- Issue 4 back-to-back reads with resp_accept held 0:
  - ready drops to 0 after the 4th accept.
  - A 5th validin sets overrun = 1, and its write does not change mem.
  - Releasing resp_accept pops 4 responses in order.
  - ready returns to 1 after the first pop.
- Steady stream of reads with resp_accept = 1 every cycle -> count stays at most 1, ready never drops, one response per cycle, FIFO pointers wrap past RDEPTH without loss.
- 17 writes to addr 3, then a read -> resp_data = 1 (16 writes wrap to 0, the 17th gives 1).
- Two reads in flight and one FIFO entry queued, assert reset for 1 cycle -> next cycle resp_valid = 0, ready = 1, overrun = 0. A read of any address returns 0 and no stale response ever appears.
